// File: rtl/cordic_coef_seq_if.sv
// Handshake bundle between the CORDIC coefficient sequencer (master) and
// the iterative CORDIC datapath that consumes (shift, coefficient) pairs (slave).
interface cordic_coef_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [SHW-1:0]   out_shift;
  logic [WIDTH-1:0] out_coef;
  logic             out_last;
  logic             done;
  logic             mode_err;

  modport master (
    input  start, abort, mode, out_ready,
    output busy, out_valid, out_shift, out_coef, out_last, done, mode_err
  );

  modport slave (
    output start, abort, mode, out_ready,
    input  busy, out_valid, out_shift, out_coef, out_last, done, mode_err
  );
endinterface

// File: rtl/cordic_coef_seq.sv
// CORDIC coefficient sequencer: streams one (shift k, f(2^-k)) pair per iteration
// for linear, circular or hyperbolic mode over a valid/ready handshake.
module cordic_coef_seq #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 10,
  parameter int N_ITER = 16,
  parameter int SHW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  cordic_coef_seq_if.master   bus
);

  // Repeat index runs 4, 13, 40, 121 - wider than the shift field.
  localparam int REPW = SHW + 3;

  localparam logic [1:0] M_LIN  = 2'b00;
  localparam logic [1:0] M_CIRC = 2'b01;
  localparam logic [1:0] M_HYP  = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIN
  } state_t;

  // NOTE: the coefficient tables are elaboration-time constants, so they carry no reset.
  logic [WIDTH-1:0] rom_lin  [N_ITER+1];
  logic [WIDTH-1:0] rom_circ [N_ITER+1];
  logic [WIDTH-1:0] rom_hyp  [N_ITER+1];

  localparam real SCALE = real'(2 ** FRAC);

  for (genvar k = 0; k <= N_ITER; k++) begin : g_rom
    localparam real X   = 1.0 / (2.0 ** k);
    // atanh(1) is infinite; the hyperbolic k=0 slot is never addressed.
    localparam real XH  = (k == 0) ? 0.5 : X;
    localparam int  LIN = $rtoi(X * SCALE + 0.5);
    localparam int  CIR = $rtoi($atan(X) * SCALE + 0.5);
    localparam int  HYP = (k == 0) ? 0 : $rtoi($atanh(XH) * SCALE + 0.5);
    assign rom_lin[k]  = WIDTH'(LIN);
    assign rom_circ[k] = WIDTH'(CIR);
    assign rom_hyp[k]  = WIDTH'(HYP);
  end

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [SHW-1:0]   k_q, k_d;       // shift of the next pair to fetch
  logic             dup_q, dup_d;   // current k already emitted once (hyperbolic repeat)
  logic [REPW-1:0]  rep_q, rep_d;
  logic [SHW-1:0]   cnt_q, cnt_d;   // transfers completed this run
  logic [SHW-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0] coef_q, coef_d;
  logic             mode_err_q, mode_err_d;

  logic             load;
  logic             last_pair;
  logic             rep_hit;
  logic [WIDTH-1:0] rom_rd;

  assign last_pair = (cnt_q == SHW'(N_ITER - 1));
  assign rep_hit   = (mode_q == M_HYP) && (REPW'(k_q) == rep_q);

  always_comb begin
    rom_rd = '0;
    case (mode_q)
      M_LIN:   rom_rd = rom_lin[k_q];
      M_CIRC:  rom_rd = rom_circ[k_q];
      M_HYP:   rom_rd = rom_hyp[k_q];
      default: rom_rd = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a latch behind.
    state_d    = state_q;
    mode_d     = mode_q;
    k_d        = k_q;
    dup_d      = dup_q;
    rep_d      = rep_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    coef_d     = coef_q;
    mode_err_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort has no meaning here, so a simultaneous start always wins.
        if (bus.start) begin
          if (bus.mode == M_RSVD) begin
            mode_err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            mode_d  = bus.mode;
            k_d     = (bus.mode == M_HYP) ? SHW'(1) : '0;
            dup_d   = 1'b0;
            rep_d   = REPW'(4);
            cnt_d   = '0;
          end
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.out_ready) begin
          if (last_pair) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + SHW'(1);
            load  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The next shift is always precomputed, so each transfer reloads the
    // output register straight from the table with no bubble.
    if (load) begin
      shift_d = k_q;
      coef_d  = rom_rd;
      if (rep_hit && !dup_q) begin
        dup_d = 1'b1;
      end else begin
        k_d   = k_q + SHW'(1);
        dup_d = 1'b0;
        if (rep_hit) begin
          rep_d = rep_q + (rep_q << 1) + REPW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      k_q        <= '0;
      dup_q      <= 1'b0;
      rep_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      coef_q     <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      dup_q      <= dup_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      coef_q     <= coef_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign bus.busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_RUN);
  assign bus.out_shift = shift_q;
  assign bus.out_coef  = coef_q;
  assign bus.out_last  = (state_q == S_RUN) && last_pair;
  assign bus.done      = (state_q == S_FIN);
  assign bus.mode_err  = mode_err_q;

endmodule

// File: tb/tb_cordic_coef_seq.sv
// Directed bench for cordic_coef_seq: table-driven full runs per mode plus
// hand-written abort, reserved-mode and asynchronous-reset sequences.
module tb_cordic_coef_seq;

  localparam int WIDTH = 16;
  localparam int SHW   = 5;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cordic_coef_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bif ();

  cordic_coef_seq #(
    .WIDTH (WIDTH),
    .FRAC  (10),
    .N_ITER(N),
    .SHW   (SHW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    bit         toggle_ready;
    bit         mid_start;
    int         shifts[N];
    int         coefs[N];
  } run_vec_t;

  run_vec_t vecs[4];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one run and consumes it to the end, checking every transferred pair.
  task automatic run_vec(input run_vec_t v);
    logic [SHW+WIDTH:0] act, exp, held;
    bit held_pending;
    bit rdy;
    int n;
    held_pending = 1'b0;
    held = '0;
    n = 0;
    bif.mode      = v.mode;
    bif.start     = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    bif.start = 1'b0;
    check({v.name, " busy/valid after start"}, {bif.busy, bif.out_valid}, 2'b10);
    tick();
    check({v.name, " first valid"}, bif.out_valid, 1'b1);
    for (int cyc = 0; cyc < 200 && n < N; cyc++) begin
      rdy = v.toggle_ready ? (cyc % 2 == 0) : 1'b1;
      bif.out_ready = rdy;
      bif.start = v.mid_start && (cyc == 5);
      if (v.mid_start && cyc == 5) bif.mode = 2'b00;
      act = {bif.out_shift, bif.out_coef, bif.out_last};
      if (held_pending) begin
        check($sformatf("%s hold before pair %0d", v.name, n), {bif.out_valid, act}, {1'b1, held});
        held_pending = 1'b0;
      end
      if (bif.out_valid && rdy) begin
        exp = {SHW'(v.shifts[n]), WIDTH'(v.coefs[n]), (n == N - 1)};
        check($sformatf("%s pair %0d", v.name, n), act, exp);
        n++;
      end else if (bif.out_valid) begin
        held = act;
        held_pending = 1'b1;
      end
      tick();
    end
    bif.start     = 1'b0;
    bif.out_ready = 1'b1;
    check({v.name, " transfer count"}, n, N);
    check({v.name, " done/busy/valid at end"}, {bif.done, bif.busy, bif.out_valid}, 3'b100);
    tick();
    check({v.name, " idle after done"}, {bif.done, bif.busy, bif.out_valid}, 3'b000);
  endtask

  initial begin
    vecs[0].name = "circ";
    vecs[0].mode = 2'b01;
    vecs[0].toggle_ready = 1'b0;
    vecs[0].mid_start = 1'b0;
    vecs[0].shifts = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    vecs[0].coefs  = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0};

    vecs[1].name = "hyp";
    vecs[1].mode = 2'b10;
    vecs[1].toggle_ready = 1'b0;
    vecs[1].mid_start = 1'b0;
    vecs[1].shifts = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
    vecs[1].coefs  = '{562, 262, 129, 64, 64, 32, 16, 8, 4, 2, 1, 1, 0, 0, 0, 0};

    vecs[2].name = "lin toggle";
    vecs[2].mode = 2'b00;
    vecs[2].toggle_ready = 1'b1;
    vecs[2].mid_start = 1'b0;
    vecs[2].shifts = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    vecs[2].coefs  = '{1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0, 0, 0, 0};

    vecs[3] = vecs[0];
    vecs[3].name = "circ busy-start";
    vecs[3].mid_start = 1'b1;

    rst           = 1'b1;
    bif.start     = 1'b0;
    bif.abort     = 1'b0;
    bif.mode      = 2'b00;
    bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs",
          {bif.busy, bif.out_valid, bif.out_shift, bif.out_coef, bif.out_last, bif.done, bif.mode_err},
          '0);
    rst = 1'b0;
    tick();

    run_vec(vecs[0]);
    run_vec(vecs[1]);
    run_vec(vecs[2]);

    // Reserved mode: error pulse, no run.
    bif.mode  = 2'b11;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    check("mode_err pulse", {bif.mode_err, bif.busy, bif.out_valid}, 3'b100);
    tick();
    check("mode_err cleared", {bif.mode_err, bif.busy, bif.out_valid}, 3'b000);
    tick();
    check("mode_err no run", {bif.busy, bif.out_valid}, 2'b00);

    // Abort after the 5th transfer with the 6th pair offered and ready high.
    bif.mode      = 2'b00;
    bif.start     = 1'b1;
    bif.out_ready = 1'b1;
    tick();
    bif.start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort run pair %0d", i), {bif.out_valid, bif.out_shift, bif.out_coef},
            {1'b1, SHW'(i), WIDTH'(1024 >> i)});
      tick();
    end
    check("abort run 6th offered", {bif.out_valid, bif.out_shift}, {1'b1, SHW'(5)});
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    check("after abort", {bif.out_valid, bif.busy, bif.done}, 3'b000);
    tick();
    check("no done after abort", {bif.out_valid, bif.busy, bif.done}, 3'b000);
    run_vec(vecs[0]);

    // start and abort together in IDLE: start wins; then abort during LOAD.
    bif.mode  = 2'b01;
    bif.start = 1'b1;
    bif.abort = 1'b1;
    tick();
    bif.start = 1'b0;
    check("start+abort in idle", {bif.busy, bif.out_valid}, 2'b10);
    tick();
    bif.abort = 1'b0;
    check("abort in load", {bif.busy, bif.out_valid, bif.done}, 3'b000);
    tick();
    run_vec(vecs[1]);

    // Asynchronous reset between clock edges in the middle of a run.
    bif.mode  = 2'b01;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (3) tick();
    check("pre-reset running", {bif.out_valid, bif.busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs",
          {bif.busy, bif.out_valid, bif.out_shift, bif.out_coef, bif.out_last, bif.done, bif.mode_err},
          '0);
    #1 rst = 1'b0;
    tick();
    check("after reset idle", {bif.busy, bif.out_valid, bif.done}, 3'b000);
    tick();
    check("no done after reset", {bif.busy, bif.out_valid, bif.done}, 3'b000);

    // start pulsed (and mode changed) mid-run must not disturb the sequence.
    run_vec(vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
